// File: rtl/match_pkg.sv
// Shared types and width helpers for the Match-path blocks.
package match_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

   // Sum of WIN squares of PIX_W-bit values never exceeds this width.
   function automatic int acc_width(input int pix_w, input int win);
      return 2 * pix_w + clog2(win);
   endfunction

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

endpackage

// File: rtl/sq_unit.sv
// Combinational PIX_W x PIX_W squarer; kept separate so it can be re-mapped.
module sq_unit #(
   parameter int PIX_W = 8
) (
   input  logic [PIX_W-1:0]   i_pix,
   output logic [2*PIX_W-1:0] o_sq
);

   logic [2*PIX_W-1:0] w_ext;

   assign w_ext = {{PIX_W{1'b0}}, i_pix};
   assign o_sq  = w_ext * w_ext;

endmodule

// File: rtl/sq_energy_acc.sv
// Streaming sum-of-squares over windows of WIN pixels, one radical per window
// held in a single-entry output register with valid/ready.
//
//   state | meaning
//   IDLE  | no partial window, acc=0 cnt=0
//   ACCUM | partial window held in acc/cnt
module sq_energy_acc
   import match_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int WIN   = 16,
   parameter int CNT_W = clog2(WIN + 1),
   parameter int ACC_W = acc_width(PIX_W, WIN)
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [PIX_W-1:0] i_in_pix,
   input  logic             i_in_sof,
   input  logic             i_in_last,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ACC_W-1:0] o_out_radical,
   output logic [CNT_W-1:0] o_out_count,
   output logic             o_flush_err
);

   acc_state_t         r_state;
   acc_state_t         w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_rdy_en;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_radical;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_flush_err;

   logic [2*PIX_W-1:0] w_sq;
   logic [ACC_W-1:0]   w_base_acc;
   logic [CNT_W-1:0]   w_base_cnt;
   logic [ACC_W-1:0]   w_sum;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_accept;
   logic               w_close;
   logic               w_wr;
   logic               w_flush;

   sq_unit #(.PIX_W(PIX_W)) u_sq (
      .i_pix (i_in_pix),
      .o_sq  (w_sq)
   );

   // r_rdy_en keeps in_ready low until the first clock after aclr release.
   assign o_in_ready = r_rdy_en && (!r_out_valid || i_out_ready);
   assign w_accept   = i_in_valid && o_in_ready;

   assign w_base_acc = i_in_sof ? '0 : r_acc;
   assign w_base_cnt = i_in_sof ? '0 : r_cnt;
   assign w_sum      = w_base_acc + ACC_W'(w_sq);
   assign w_cnt_inc  = w_base_cnt + CNT_W'(1);
   assign w_close    = i_in_last || (w_cnt_inc == CNT_W'(WIN));
   assign w_flush    = w_accept && i_in_sof && (r_state == ACCUM) && (r_cnt != '0);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_wr        = 1'b0;
      if (w_accept) begin
         if (w_close) begin
            w_wr        = 1'b1;
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = ACCUM;
            w_acc_nxt   = w_sum;
            w_cnt_nxt   = w_cnt_inc;
         end
      end
   end

   // Output register: a new write wins over the consumer taking the old value.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_rdy_en      <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_radical <= '0;
         r_out_count   <= '0;
         r_flush_err   <= 1'b0;
      end else begin
         r_rdy_en    <= 1'b1;
         r_flush_err <= w_flush;
         if (w_wr) begin
            r_out_valid   <= 1'b1;
            r_out_radical <= w_sum;
            r_out_count   <= w_cnt_inc;
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_valid   = r_out_valid;
   assign o_out_radical = r_out_radical;
   assign o_out_count   = r_out_count;
   assign o_flush_err   = r_flush_err;

endmodule

// File: tb/tb_sq_energy_acc.sv
// Directed bench for sq_energy_acc: model-driven scoreboard of window results.
module tb_sq_energy_acc;

   localparam int PIX_W = 8;
   localparam int WIN   = 16;
   localparam int CNT_W = 5;
   localparam int ACC_W = 20;

   logic             clk;
   logic             aclr;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [PIX_W-1:0] i_in_pix;
   logic             i_in_sof;
   logic             i_in_last;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [ACC_W-1:0] o_out_radical;
   logic [CNT_W-1:0] o_out_count;
   logic             o_flush_err;

   int n_checks = 0;
   int n_errors = 0;
   int m_acc    = 0;
   int m_cnt    = 0;
   int exp_flush = 0;
   int n_flush  = 0;
   int exp_rad[$];
   int exp_cnt[$];

   sq_energy_acc #(.PIX_W(PIX_W), .WIN(WIN)) dut (
      .clk           (clk),
      .aclr          (aclr),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_in_pix      (i_in_pix),
      .i_in_sof      (i_in_sof),
      .i_in_last     (i_in_last),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out_radical (o_out_radical),
      .o_out_count   (o_out_count),
      .o_flush_err   (o_flush_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop: a transfer happens at the next edge when valid && ready.
   always @(negedge clk) begin
      if (!aclr && o_out_valid && i_out_ready) begin
         if (exp_rad.size() == 0) begin
            chk("unexpected_out", exp_rad.size(), 1);
         end else begin
            chk("out_radical", int'(o_out_radical), exp_rad.pop_front());
            chk("out_count", int'(o_out_count), exp_cnt.pop_front());
         end
      end
      if (!aclr && o_flush_err) n_flush++;
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int pix, input bit sof, input bit last);
      bit done;
      int base_a;
      int base_c;
      done = 1'b0;
      i_in_valid = 1'b1;
      i_in_pix   = pix[PIX_W-1:0];
      i_in_sof   = sof;
      i_in_last  = last;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (o_in_ready) begin
            done = 1'b1;
            if (sof && m_cnt > 0) exp_flush++;
            base_a = sof ? 0 : m_acc;
            base_c = sof ? 0 : m_cnt;
            if (last || base_c + 1 == WIN) begin
               exp_rad.push_back(base_a + pix * pix);
               exp_cnt.push_back(base_c + 1);
               m_acc = 0;
               m_cnt = 0;
            end else begin
               m_acc = base_a + pix * pix;
               m_cnt = base_c + 1;
            end
         end
         @(posedge clk);
         #1;
      end
      chk("send_accepted", int'(done), 1);
      i_in_valid = 1'b0;
      i_in_sof   = 1'b0;
      i_in_last  = 1'b0;
   endtask

   initial begin
      aclr        = 1'b1;
      i_in_valid  = 1'b0;
      i_in_pix    = '0;
      i_in_sof    = 1'b0;
      i_in_last   = 1'b0;
      i_out_ready = 1'b1;

      #12;
      chk("rst_in_ready", int'(o_in_ready), 0);
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_out_radical", int'(o_out_radical), 0);
      chk("rst_out_count", int'(o_out_count), 0);
      chk("rst_flush_err", int'(o_flush_err), 0);
      #1 aclr = 1'b0;
      step(1);
      chk("in_ready_after_rst", int'(o_in_ready), 1);

      // Full window 1..16, valid for exactly one cycle.
      for (int p = 1; p <= 16; p++) send(p, 1'b0, p == 16);
      @(negedge clk);
      chk("full_valid_1", int'(o_out_valid), 1);
      chk("full_radical", int'(o_out_radical), 1496);
      @(negedge clk);
      chk("full_valid_0", int'(o_out_valid), 0);
      step(1);

      // Early close, then a fresh window from zero.
      send(3, 1'b0, 1'b0);
      send(4, 1'b0, 1'b1);
      send(1, 1'b0, 1'b0);
      send(1, 1'b0, 1'b1);
      step(2);

      // Backpressure on a full window of 255s.
      i_out_ready = 1'b0;
      for (int k = 0; k < 16; k++) send(255, 1'b0, 1'b0);
      i_in_valid = 1'b1;
      i_in_pix   = 8'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", int'(o_in_ready), 0);
         chk("bp_valid", int'(o_out_valid), 1);
         chk("bp_radical", int'(o_out_radical), 1040400);
         chk("bp_count", int'(o_out_count), 16);
      end
      step(1);
      i_out_ready = 1'b1;
      for (int k = 0; k < 16; k++) send(3, 1'b0, 1'b0);
      step(2);

      // Flush: partial window discarded by in_sof.
      n_flush = 0;
      exp_flush = 0;
      for (int k = 0; k < 5; k++) send(10, 1'b0, 1'b0);
      send(2, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) send(1, 1'b0, 1'b0);
      step(2);
      chk("flush_pulses", n_flush, exp_flush);
      chk("flush_once", n_flush, 1);

      // Close in the same cycle the held result is taken.
      i_out_ready = 1'b0;
      send(7, 1'b0, 1'b1);
      i_out_ready = 1'b1;
      send(8, 1'b0, 1'b1);
      @(negedge clk);
      chk("sim_valid", int'(o_out_valid), 1);
      chk("sim_radical", int'(o_out_radical), 64);
      step(1);
      send(9, 1'b1, 1'b1);
      @(negedge clk);
      chk("sof_last_count", int'(o_out_count), 1);
      step(2);

      // Async reset mid-window.
      for (int k = 0; k < 7; k++) send(5, 1'b0, 1'b0);
      @(posedge clk);
      #3 aclr = 1'b1;
      #1;
      chk("mid_rst_valid", int'(o_out_valid), 0);
      chk("mid_rst_radical", int'(o_out_radical), 0);
      chk("mid_rst_count", int'(o_out_count), 0);
      chk("mid_rst_in_ready", int'(o_in_ready), 0);
      exp_rad.delete();
      exp_cnt.delete();
      m_acc = 0;
      m_cnt = 0;
      #2 aclr = 1'b0;
      step(1);
      chk("post_rst_in_ready", int'(o_in_ready), 1);
      for (int k = 0; k < 16; k++) send(2, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_radical", int'(o_out_radical), 64);
      step(3);
      chk("queue_empty", exp_rad.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
